hazard_fwd_ctrl: RTL

//  Consumer-side controller for the ID/EX pipeline interface. Watches the EX-stage fields the ID/EX

---
 rtl/hazard_fwd_ctrl_pkg.sv | 14 +
 rtl/hazard_fwd_ctrl_if.sv | 24 ++
 rtl/hazard_fwd_ctrl_fwd_sel_unit.sv | 23 ++
 rtl/hazard_fwd_ctrl.sv | 58 +++++
 4 files changed

// File: rtl/hazard_fwd_ctrl_pkg.sv
// hazard_fwd_ctrl_pkg: shared FSM encodings, forwarding select codes and default widths.
package hazard_fwd_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_LSTALL = 2'b01,
    ST_HOLD   = 2'b10
  } state_t;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;
  localparam int REGW_DEF    = 5;
  localparam int STALLCW_DEF = 16;
endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// hazard_fwd_ctrl_if: pipeline-side fields into the hazard controller and its control outputs back to ID.
interface hazard_fwd_ctrl_if
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REGW    = REGW_DEF,
  parameter int STALLCW = STALLCW_DEF
);
  logic [REGW-1:0]    id_rs, id_rt, ex_dest, mem_dest, wb_dest;
  logic               id_use_rs, id_use_rt;
  logic               ex_rf_en, ex_load, mem_rf_en, wb_rf_en, mem_wait;
  logic [1:0]         fwd_a_sel, fwd_b_sel;
  logic               pc_ld, ifid_ld, idex_ld, id_nop;
  logic [STALLCW-1:0] stall_cnt;
  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_dest, ex_rf_en, ex_load,
           mem_dest, mem_rf_en, wb_dest, wb_rf_en, mem_wait,
    input  fwd_a_sel, fwd_b_sel, pc_ld, ifid_ld, idex_ld, id_nop, stall_cnt
  );
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_dest, ex_rf_en, ex_load,
           mem_dest, mem_rf_en, wb_dest, wb_rf_en, mem_wait,
    output fwd_a_sel, fwd_b_sel, pc_ld, ifid_ld, idex_ld, id_nop, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_ctrl_fwd_sel_unit.sv
// fwd_sel_unit: priority (EX > MEM > WB) forwarding select for one ID source operand.
module fwd_sel_unit
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REGW = REGW_DEF
) (
  input  logic [REGW-1:0] src,
  input  logic            use_src,
  input  logic [REGW-1:0] ex_dest,
  input  logic            ex_rf_en,
  input  logic [REGW-1:0] mem_dest,
  input  logic            mem_rf_en,
  input  logic [REGW-1:0] wb_dest,
  input  logic            wb_rf_en,
  output logic [1:0]      sel
);
  logic live;
  assign live = use_src && (src != '0);
  assign sel = !live                          ? FWD_RF  :
               (ex_rf_en  && ex_dest  == src) ? FWD_EX  :
               (mem_rf_en && mem_dest == src) ? FWD_MEM :
               (wb_rf_en  && wb_dest  == src) ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: ID-stage forwarding selects, load-use bubble and data-memory hold sequencing.
// Optional saturating stall counter enabled by defining HZ_STALL_CNT_EN.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REGW    = REGW_DEF,
  parameter int STALLCW = STALLCW_DEF
) (
  input logic              clk,
  input logic              reset,
  hazard_fwd_ctrl_if.slave bus
);
  state_t     state, state_nxt;
  logic       hit, bubble, hold, pc_ld;
  logic [1:0] sel_a, sel_b;
  fwd_sel_unit #(.REGW(REGW)) u_fwd_a (
    .src(bus.id_rs), .use_src(bus.id_use_rs),
    .ex_dest(bus.ex_dest), .ex_rf_en(bus.ex_rf_en),
    .mem_dest(bus.mem_dest), .mem_rf_en(bus.mem_rf_en),
    .wb_dest(bus.wb_dest), .wb_rf_en(bus.wb_rf_en),
    .sel(sel_a)
  );
  fwd_sel_unit #(.REGW(REGW)) u_fwd_b (
    .src(bus.id_rt), .use_src(bus.id_use_rt),
    .ex_dest(bus.ex_dest), .ex_rf_en(bus.ex_rf_en),
    .mem_dest(bus.mem_dest), .mem_rf_en(bus.mem_rf_en),
    .wb_dest(bus.wb_dest), .wb_rf_en(bus.wb_rf_en),
    .sel(sel_b)
  );
  assign hit = bus.ex_load && bus.ex_rf_en && (bus.ex_dest != '0) &&
               ((bus.id_use_rs && bus.id_rs == bus.ex_dest) ||
                (bus.id_use_rt && bus.id_rt == bus.ex_dest));
  // mem_wait outranks a load-use hit; the hit is seen again once back in RUN
  always_comb begin
    state_nxt = bus.mem_wait ? ST_HOLD : (state == ST_RUN && hit) ? ST_LSTALL : ST_RUN;
    bubble    = (state == ST_RUN) && hit;
    hold      = (state == ST_HOLD);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  assign pc_ld         = !reset && !hold && !bubble;
  assign bus.pc_ld     = pc_ld;
  assign bus.ifid_ld   = pc_ld;
  assign bus.idex_ld   = reset || !hold;
  assign bus.id_nop    = reset || bubble;
  assign bus.fwd_a_sel = reset ? FWD_RF : sel_a;
  assign bus.fwd_b_sel = reset ? FWD_RF : sel_b;
`ifdef HZ_STALL_CNT_EN
  logic [STALLCW-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset)               cnt <= '0;
    else if (!pc_ld && ~&cnt) cnt <= cnt + 1'b1;
  assign bus.stall_cnt = cnt;
`else
  assign bus.stall_cnt = {STALLCW{1'b0}};
`endif
endmodule
